load_store_unit: RTL and testbench

- Sits directly upstream of the word-addressed data memory. Turns CPU load/store requests (LB, LBU, LH, LHU, LW, SB, SH, SW) into word accesses on the memory port.
- The memory port offers a combinational read and a posedge write, both selected by word address = byte address >> 2.
- Sub-word stores use a read-modify-write sequence. Loads extract the addressed byte or halfword and sign-extend or zero-extend it.
- Byte order is big-endian: byte offset 0 = bits [31:24].

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and op-decode helpers for the load/store unit.
// Op encodings match the req_op port bit-for-bit.
package lsu_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } mem_op_t;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} lsu_state_t;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

   function automatic logic is_load(mem_op_t op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic is_store(mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic acc_size_t access_size(mem_op_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         default:              return SZ_WORD;
      endcase
   endfunction

   function automatic logic misaligned(mem_op_t op, logic [1:0] off);
      case (access_size(op))
         SZ_HALF: return off[0];
         SZ_WORD: return |off;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction for loads and lane merge for sub-word stores.
// Purely combinational; offset 0 is the most significant byte.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  mem_op_t            op_i,
   input  logic [1:0]         off_i,
   input  logic [WORD_W-1:0]  word_i,
   input  logic [WORD_W-1:0]  wdata_i,
   output logic [WORD_W-1:0]  load_o,
   output logic [WORD_W-1:0]  store_o
);

   // Byte k sits at bit 8*(3-k); ~off equals 3-off for a 2-bit offset.
   logic [4:0]  sh;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign sh     = {~off_i, 3'b000};
   assign byte_v = 8'(word_i >> sh);
   assign half_v = off_i[1] ? word_i[15:0] : word_i[31:16];

   always_comb begin
      load_o = word_i;
      case (op_i)
         OP_LB:   load_o = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  load_o = {24'h0, byte_v};
         OP_LH:   load_o = {{16{half_v[15]}}, half_v};
         OP_LHU:  load_o = {16'h0, half_v};
         default: load_o = word_i;
      endcase
   end

   always_comb begin
      store_o = wdata_i;
      case (op_i)
         OP_SB:   store_o = (word_i & ~(32'h0000_00FF << sh)) |
                            ({24'h0, wdata_i[7:0]} << sh);
         OP_SH:   store_o = off_i[1] ? {word_i[31:16], wdata_i[15:0]}
                                     : {wdata_i[15:0], word_i[15:0]};
         default: store_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// CPU load/store front end for a word-addressed memory with combinational read.
// Sub-word stores are done as read-modify-write through the RD and WR states.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              addr_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_readdata
);

   lsu_state_t        state_q, state_d;
   mem_op_t           op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   mem_op_t           req_op_e;
   logic              req_bad;
   logic [DATA_W-1:0] load_val, store_val;

   assign req_op_e = mem_op_t'(req_op);
   assign req_bad  = misaligned(req_op_e, req_addr[1:0]);

   // word_q holds the store data until RD overwrites it with the merged word.
   lsu_lane_align u_align (
      .op_i    (op_q),
      .off_i   (addr_q[1:0]),
      .word_i  (mem_readdata),
      .wdata_i (word_q),
      .load_o  (load_val),
      .store_o (store_val)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req_valid) begin
            if (req_bad)                 state_d = DONE;
            else if (req_op_e == OP_SW)  state_d = WR;
            else                         state_d = RD;
         end
         RD:      state_d = is_load(op_q) ? DONE : WR;
         WR:      state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready    = (state_q == IDLE);
      done     = (state_q == DONE);
      mem_read = (state_q == RD);
      mem_write= (state_q == WR);
      addr_err = (state_q == DONE) && err_q;
   end

   always_comb begin
      op_d    = op_q;
      addr_d  = addr_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (state_q == IDLE && req_valid) begin
         op_d   = req_op_e;
         addr_d = req_addr;
         word_d = req_wdata;
         err_d  = req_bad;
      end else if (state_q == RD) begin
         if (is_load(op_q)) rdata_d = load_val;
         else               word_d  = store_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q    <= OP_LB;
         addr_q  <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         op_q    <= op_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign rdata         = rdata_q;
   assign mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_writedata = word_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural word memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        ready, done, addr_err, mem_read, mem_write;
   logic [31:0] rdata, mem_address, mem_writedata, mem_readdata;

   logic [31:0] mem [0:63];
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_op        (req_op),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .ready         (ready),
      .done          (done),
      .rdata         (rdata),
      .addr_err      (addr_err),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_readdata  (mem_readdata)
   );

   assign mem_readdata = mem[mem_address[7:2]];

   always @(posedge clk) begin
      if (pl_en)          mem[pl_idx] <= pl_data;
      else if (mem_write) mem[mem_address[7:2]] <= mem_writedata;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
      end
   endtask

   // One request: latency counted in negedges after the accepting edge.
   task automatic xact(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input int exp_lat, input logic exp_err,
                       input int exp_rd, input int exp_wr);
      int lat, rd, wr, both;
      bit seen;
      @(negedge clk);
      chk({tag, " ready"}, {31'b0, ready}, 32'd1);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1 req_valid = 1'b0;
      lat = 0; rd = 0; wr = 0; both = 0; seen = 0;
      while (!seen && lat < 8) begin
         @(negedge clk);
         lat++;
         if (mem_read)  rd++;
         if (mem_write) wr++;
         if (mem_read && mem_write) both++;
         if (done) begin
            seen = 1;
            chk({tag, " addr_err"}, {31'b0, addr_err}, {31'b0, exp_err});
         end
      end
      chk({tag, " latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
      chk({tag, " rd cycles"}, 32'(rd), 32'(exp_rd));
      chk({tag, " wr cycles"}, 32'(wr), 32'(exp_wr));
      chk({tag, " strobe overlap"}, 32'(both), 32'd0);
      @(negedge clk);
      chk({tag, " done pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int d1, d2, acc;
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
      pl_en = 1'b1; pl_idx = 6'd4; pl_data = 32'h8081_7F02;
      @(posedge clk); #1 pl_en = 1'b0;
      chk("rst ready", {31'b0, ready}, 32'd1);
      chk("rst done", {31'b0, done}, 32'd0);
      chk("rst addr_err", {31'b0, addr_err}, 32'd0);
      chk("rst strobes", {30'b0, mem_read, mem_write}, 32'd0);
      chk("rst rdata", rdata, 32'd0);
      chk("rst mem_address", mem_address, 32'd0);
      chk("rst mem_writedata", mem_writedata, 32'd0);
      @(negedge clk); reset = 1'b0;

      // Loads on word 0x10 = 0x80817F02
      xact("LB 10", 3'd0, 32'h10, 32'h0, 2, 1'b0, 1, 0);
      chk("LB 10 rdata", rdata, 32'hFFFF_FF80);
      xact("LBU 11", 3'd1, 32'h11, 32'h0, 2, 1'b0, 1, 0);
      chk("LBU 11 rdata", rdata, 32'h0000_0081);
      xact("LH 12", 3'd2, 32'h12, 32'h0, 2, 1'b0, 1, 0);
      chk("LH 12 rdata", rdata, 32'h0000_7F02);
      xact("LHU 10", 3'd3, 32'h10, 32'h0, 2, 1'b0, 1, 0);
      chk("LHU 10 rdata", rdata, 32'h0000_8081);
      xact("LW 10", 3'd4, 32'h10, 32'h0, 2, 1'b0, 1, 0);
      chk("LW 10 rdata", rdata, 32'h8081_7F02);

      // Sub-word stores
      xact("SB 13", 3'd5, 32'h13, 32'h1234_56AA, 3, 1'b0, 1, 1);
      chk("SB 13 mem", mem[4], 32'h8081_7FAA);
      chk("SB 13 rdata held", rdata, 32'h8081_7F02);
      xact("SW restore", 3'd7, 32'h10, 32'h8081_7F02, 2, 1'b0, 0, 1);
      chk("restore mem", mem[4], 32'h8081_7F02);
      xact("SH 10", 3'd6, 32'h10, 32'hFFFF_1234, 3, 1'b0, 1, 1);
      chk("SH 10 mem", mem[4], 32'h1234_7F02);
      xact("SB 10", 3'd5, 32'h10, 32'h0000_0080, 3, 1'b0, 1, 1);
      chk("SB 10 mem", mem[4], 32'h8034_7F02);
      xact("SH 12", 3'd6, 32'h12, 32'h0000_BEEF, 3, 1'b0, 1, 1);
      chk("SH 12 mem", mem[4], 32'h8034_BEEF);
      xact("LB 11", 3'd0, 32'h11, 32'h0, 2, 1'b0, 1, 0);
      chk("LB 11 rdata", rdata, 32'h0000_0034);
      xact("LH 12b", 3'd2, 32'h12, 32'h0, 2, 1'b0, 1, 0);
      chk("LH 12b rdata", rdata, 32'hFFFF_BEEF);
      xact("SW 14", 3'd7, 32'h14, 32'hDEAD_BEEF, 2, 1'b0, 0, 1);
      chk("SW 14 mem", mem[5], 32'hDEAD_BEEF);

      // Misaligned requests
      xact("LW 12 err", 3'd4, 32'h12, 32'h0, 1, 1'b1, 0, 0);
      chk("LW err rdata held", rdata, 32'hFFFF_BEEF);
      xact("SH 11 err", 3'd6, 32'h11, 32'h0000_5555, 1, 1'b1, 0, 0);
      chk("SH err mem", mem[4], 32'h8034_BEEF);
      xact("LB 13 ok", 3'd0, 32'h13, 32'h0, 2, 1'b0, 1, 0);
      chk("LB 13 rdata", rdata, 32'hFFFF_FFEF);

      // Back-to-back: SW then held LW, accepted the cycle after DONE
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h10; req_wdata = 32'h1122_3344;
      @(posedge clk); #1 req_op = 3'd4;
      d1 = 0; d2 = 0; acc = 0;
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk);
         if (done && d1 == 0) d1 = n;
         else if (done) d2 = n;
         if (ready && acc == 0) begin
            acc = n;
            @(posedge clk); #1 req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("b2b SW done", 32'(d1), 32'd2);
      chk("b2b accept", 32'(acc), 32'd3);
      chk("b2b LW done", 32'(d2), 32'd5);
      chk("b2b LW rdata", rdata, 32'h1122_3344);

      xact("SW restore2", 3'd7, 32'h10, 32'h8081_7F02, 2, 1'b0, 0, 1);

      // Reset while SH is in WR
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h10; req_wdata = 32'h0000_ABCD;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstWR in RD", {31'b0, mem_read}, 32'd1);
      @(negedge clk);
      chk("rstWR in WR", {31'b0, mem_write}, 32'd1);
      chk("rstWR merged", mem_writedata, 32'hABCD_7F02);
      #2 reset = 1'b1;
      #1;
      chk("rstWR mem_write", {31'b0, mem_write}, 32'd0);
      chk("rstWR mem_read", {31'b0, mem_read}, 32'd0);
      chk("rstWR done", {31'b0, done}, 32'd0);
      chk("rstWR rdata", rdata, 32'd0);
      chk("rstWR mem_address", mem_address, 32'd0);
      chk("rstWR mem_writedata", mem_writedata, 32'd0);
      @(posedge clk); #1;
      chk("rstWR mem kept", mem[4], 32'h8081_7F02);
      @(negedge clk); reset = 1'b0;
      xact("LW post-rst", 3'd4, 32'h10, 32'h0, 2, 1'b0, 1, 0);
      chk("LW post-rst rdata", rdata, 32'h8081_7F02);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
